// File: rtl/add_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | add_pkg : shared types and step derivation for the serial adder  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package add_pkg;

   localparam int SLICE_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } add_state_t;

   function automatic int add_steps(input int width);
      return width / SLICE_W;
   endfunction

   // A single-step configuration still needs a 1-bit counter.
   function automatic int add_step_w(input int width);
      int s;
      s = add_steps(width);
      return (s > 1) ? $clog2(s) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla2_slice.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cla2_slice : 2-bit carry-lookahead adder slice (combinational)   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module cla2_slice (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       ci,
   output logic [1:0] s,
   output logic       co
);

   logic [1:0] w_g;
   logic [1:0] w_p;
   logic       w_c1;

   assign w_g  = a & b;
   assign w_p  = a ^ b;
   assign w_c1 = w_g[0] | (w_p[0] & ci);
   assign co   = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
   assign s    = {w_p[1] ^ w_c1, w_p[0] ^ ci};

endmodule
`default_nettype wire

// File: rtl/add64_serial_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | add64_serial_ctrl : sequenced adder reusing one 2-bit CLA slice  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module add64_serial_ctrl
   import add_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int STEPS  = add_steps(WIDTH);
   localparam int STEP_W = add_step_w(WIDTH);
   localparam logic [STEP_W-1:0] C_LAST_STEP = STEP_W'(STEPS - 1);

   add_state_t        r_state;
   add_state_t        w_state_nxt;
   logic              w_accept;

   logic [STEP_W-1:0] r_step;
   logic              r_carry;
   logic [WIDTH-1:0]  r_sh_a;
   logic [WIDTH-1:0]  r_sh_b;
   logic [WIDTH-1:0]  r_sum;
   logic              r_sa;
   logic              r_sb;
   logic              r_start_ready;
   logic              r_done_valid;
   logic              r_busy;

   logic [1:0]        w_s;
   logic              w_co;

   cla2_slice u_slice (
      .a  (r_sh_a[1:0]),
      .b  (r_sh_b[1:0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_valid && r_start_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (r_step == C_LAST_STEP) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (r_done_valid && done_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Handshake flags follow the next state so they are pure register outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start_ready <= 1'b0;
         r_done_valid  <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_start_ready <= (w_state_nxt == IDLE);
         r_done_valid  <= (w_state_nxt == DONE);
         r_busy        <= (w_state_nxt != IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step  <= '0;
         r_carry <= 1'b0;
         r_sh_a  <= '0;
         r_sh_b  <= '0;
         r_sum   <= '0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
      end else if (w_accept) begin
         r_step  <= '0;
         r_carry <= cin;
         r_sh_a  <= a;
         r_sh_b  <= b;
         r_sa    <= a[WIDTH-1];
         r_sb    <= b[WIDTH-1];
      end else if (r_state == RUN) begin
         r_sh_a  <= r_sh_a >> SLICE_W;
         r_sh_b  <= r_sh_b >> SLICE_W;
         r_sum   <= {w_s, r_sum[WIDTH-1:SLICE_W]};
         r_carry <= w_co;
         // Counter parks on the last step instead of wrapping.
         if (r_step != C_LAST_STEP) begin
            r_step <= r_step + 1'b1;
         end
      end
   end

   assign start_ready = r_start_ready;
   assign done_valid  = r_done_valid;
   assign busy        = r_busy;
   assign sum         = r_sum;
   assign cout        = r_carry;
   assign ovf         = (r_sa == r_sb) && (r_sum[WIDTH-1] != r_sa);

endmodule
`default_nettype wire

// File: tb/tb_add64_serial_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_add64_serial_ctrl : scoreboard bench for the serial adder     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_add64_serial_ctrl;

   localparam int WIDTH = 64;
   localparam int STEPS = WIDTH / 2;

   logic             clk;
   logic             rst_n;
   logic             start_valid;
   logic             start_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             done_valid;
   logic             done_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;

   add64_serial_ctrl #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .a           (a),
      .b           (b),
      .cin         (cin),
      .done_valid  (done_valid),
      .done_ready  (done_ready),
      .sum         (sum),
      .cout        (cout),
      .ovf         (ovf),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   logic [65:0] exp_q[$];
   int          acc_q[$];
   int          last_acc;
   logic        prev_dv = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
      end
   endtask

   // {ovf, cout, sum} from plain arithmetic on the operands
   function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y, input logic c);
      logic [64:0] t;
      logic        o;
      t = {1'b0, x} + {1'b0, y} + {64'd0, c};
      o = (x[63] == y[63]) && (t[63] != x[63]);
      return {o, t};
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (done_valid && !prev_dv) begin
            if (acc_q.size() == 0) chk("latency_orphan", 64'd1, 64'd0);
            else chk("latency", 64'(cyc - acc_q.pop_front()), 64'(STEPS));
         end
         if (done_valid && done_ready) begin
            if (exp_q.size() == 0) begin
               chk("result_orphan", 64'd1, 64'd0);
            end else begin
               logic [65:0] e;
               e = exp_q.pop_front();
               chk("sum", sum, e[63:0]);
               chk("cout", {63'd0, cout}, {63'd0, e[64]});
               chk("ovf", {63'd0, ovf}, {63'd0, e[65]});
            end
         end
      end
      prev_dv = rst_n ? done_valid : 1'b0;
   end

   task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic icin,
                        input bit push, input bit chk_gap);
      int n;
      n = 0;
      @(negedge clk);
      while (!start_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!start_ready) begin
         chk("start_ready_timeout", 64'd0, 64'd1);
         return;
      end
      a = ia;
      b = ib;
      cin = icin;
      start_valid = 1'b1;
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      if (push) begin
         exp_q.push_back(model(ia, ib, icin));
         acc_q.push_back(cyc);
      end
      if (chk_gap && last_acc >= 0) chk("spacing", 64'(cyc - last_acc), 64'(STEPS + 2));
      last_acc = cyc;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_start_ready"}, {63'd0, start_ready}, 64'd0);
      chk({tag, "_done_valid"}, {63'd0, done_valid}, 64'd0);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_sum"}, sum, 64'd0);
      chk({tag, "_cout"}, {63'd0, cout}, 64'd0);
      chk({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !start_ready) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [63:0] fs;
      logic        fc;
      logic        fo;
      int          n;

      rst_n = 1'b0;
      start_valid = 1'b0;
      done_ready = 1'b1;
      a = '0;
      b = '0;
      cin = 1'b0;
      last_acc = -1;

      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);
      chk("start_ready_after_reset", {63'd0, start_ready}, 64'd1);

      issue(64'd1, 64'd1, 1'b0, 1, 0);
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1, 0);
      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1, 0);
      issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1, 0);
      drain();

      // back-pressure: result frozen, requests ignored
      done_ready = 1'b0;
      issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1, 0);
      n = 0;
      while (!done_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_done_seen", {63'd0, done_valid}, 64'd1);
      fs = sum;
      fc = cout;
      fo = ovf;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start_valid = 1'($urandom);
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         chk("bp_sum_frozen", sum, fs);
         chk("bp_cout_frozen", {63'd0, cout}, {63'd0, fc});
         chk("bp_ovf_frozen", {63'd0, ovf}, {63'd0, fo});
         chk("bp_start_ready", {63'd0, start_ready}, 64'd0);
         chk("bp_done_valid", {63'd0, done_valid}, 64'd1);
      end
      @(posedge clk);
      #2;
      start_valid = 1'b0;
      done_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_done_valid", {63'd0, done_valid}, 64'd0);
      chk("bp_release_start_ready", {63'd0, start_ready}, 64'd1);
      chk("bp_release_busy", {63'd0, busy}, 64'd0);
      repeat (3) @(negedge clk);
      chk("bp_no_second_request", {63'd0, busy}, 64'd0);
      chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

      // reset in the middle of an add
      issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 0, 0);
      repeat (15) @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrun");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1, 0);
      drain();

      last_acc = -1;
      for (int i = 0; i < 1000; i++) begin
         issue({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1, 1);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
